// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcode encodings of the
// upstream 4-bit ALU and bit positions of the {N,Z,C,V} flag vector.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

endpackage : alu_pkg

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V flag derivation from one ALU transfer.
// Carry is only meaningful for the arithmetic ops; logical ops clear C and V.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             cout_i,
    output flags_t           flags_o
);

    localparam int MSB = WIDTH - 1;

    // Largest positive / most negative two's-complement operand values.
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Only the sign bit of b takes part in overflow detection.
    logic unused_b_low;
    assign unused_b_low = ^b_i[MSB-1:0];

    // Derive flags; C and V depend on the opcode class.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        flags_o         = '0;
        flags_o[FLAG_N] = y_i[MSB];
        flags_o[FLAG_Z] = (y_i == '0);
        case (op_i)
            OP_ADD: begin
                flags_o[FLAG_C] = cout_i;
                flags_o[FLAG_V] = (a_i[MSB] == b_i[MSB]) && (y_i[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                flags_o[FLAG_C] = cout_i;
                flags_o[FLAG_V] = (a_i[MSB] != b_i[MSB]) && (y_i[MSB] != a_i[MSB]);
            end
            OP_INC: begin
                flags_o[FLAG_C] = cout_i;
                flags_o[FLAG_V] = (a_i == MAX_POS);
            end
            OP_DEC: begin
                flags_o[FLAG_C] = cout_i;
                flags_o[FLAG_V] = (a_i == MIN_NEG);
            end
            default: ;
        endcase
    end

endmodule : alu_flag_gen

// File: rtl/alu_result_stage.sv
// Registered result/flag stage behind the 4-bit ALU: each accepted transfer
// stores {op, y, flags} in a DEPTH-entry FIFO with valid/ready on both sides.
// The head entry is read combinationally; there is no write-to-read bypass.
// Optional build macro ALU_STICKY_FLAGS_EN adds sticky_flags/sticky_clr,
// accumulating the flags of every popped entry.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [WIDTH-1:0]           in_y,
    input  logic [3:0]                 in_cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_op,
    output logic [WIDTH-1:0]           out_y,
    output logic [3:0]                 out_flags,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic                       sticky_clr,
    output logic [3:0]                 sticky_flags
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] y;
        flags_t           flags;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    flags_t             in_flags;
    logic               push, pop;

    // Only carry bit 0 of the ALU is architecturally meaningful.
    logic unused_cout_high;
    assign unused_cout_high = ^in_cout[3:1];

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .op_i    (in_op),
        .a_i     (in_a),
        .b_i     (in_b),
        .y_i     (in_y),
        .cout_i  (in_cout[0]),
        .flags_o (in_flags)
    );

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_op    = mem_q[rd_ptr_q].op;
    assign out_y     = mem_q[rd_ptr_q].y;
    assign out_flags = mem_q[rd_ptr_q].flags;
    assign count     = count_q;

    // Next-state for pointers and occupancy; pointers wrap since DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the write pointer on each accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is deliberately reset so the head outputs read 0 straight after reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{op: in_op, y: in_y, flags: in_flags};
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic [3:0] sticky_q;

    assign sticky_flags = sticky_q;

    // Accumulate flags of popped entries; a clear request takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= '0;
        end else if (sticky_clr) begin
            sticky_q <= '0;
        end else if (pop) begin
            sticky_q <= sticky_q | out_flags;
        end
    end
`endif

endmodule : alu_result_stage

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: flag vector table, random
// traffic against a queue model, full/wrap, streaming with async reset,
// and (when ALU_STICKY_FLAGS_EN is defined) sticky flag accumulation.
module tb_alu_result_stage;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a, in_b, in_y;
    logic [3:0]       in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_op;
    logic [WIDTH-1:0] out_y;
    logic [3:0]       out_flags;
    logic [CNT_W-1:0] count;
`ifdef ALU_STICKY_FLAGS_EN
    logic             sticky_clr;
    logic [3:0]       sticky_flags;
`endif

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_y      (in_y),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_y     (out_y),
        .out_flags (out_flags),
        .count     (count)
`ifdef ALU_STICKY_FLAGS_EN
        ,
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a, b, y, cout;
        logic [3:0] flags;
    } vec_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] y;
        logic [3:0] flags;
    } ent_t;

    ent_t model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] y, input logic [3:0] cout,
                         input logic rdy);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_y      = y;
        in_cout   = cout;
        out_ready = rdy;
    endtask

    // Ideal 4-bit ALU result, used to make random stimulus realistic.
    function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a + 4'd1;
            3'd3:    return a - 4'd1;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Flags from signed-integer reasoning: V means the true result leaves [-8,7].
    function automatic logic [3:0] ref_flags(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b, input logic [3:0] y,
                                             input logic [3:0] cout);
        int sa, sb, r;
        logic n, z, c, v;
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        n  = (y >= 8);
        z  = (y == 0);
        c  = (op < 4) ? cout[0] : 1'b0;
        r  = 0;
        v  = 1'b0;
        case (op)
            3'd0: begin r = sa + sb; v = (r > 7) || (r < -8); end
            3'd1: begin r = sa - sb; v = (r > 7) || (r < -8); end
            3'd2: begin r = sa + 1;  v = (r > 7); end
            3'd3: begin r = sa - 1;  v = (r < -8); end
            default: v = 1'b0;
        endcase
        return {n, z, c, v};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        logic exp_push, exp_pop;
        logic v, r;
        logic [2:0] op;
        logic [3:0] a, b, y, cout;
        ent_t e;

        vecs[0]  = '{3'b000, 4'b0111, 4'b0001, 4'b1000, 4'b0000, 4'b1001};
        vecs[1]  = '{3'b001, 4'd2,    4'd3,    4'b1111, 4'b1111, 4'b1010};
        vecs[2]  = '{3'b110, 4'd5,    4'd5,    4'b0000, 4'b1111, 4'b0100};
        vecs[3]  = '{3'b010, 4'b0111, 4'd0,    4'b1000, 4'b0000, 4'b1001};
        vecs[4]  = '{3'b011, 4'b1000, 4'd0,    4'b0111, 4'b0001, 4'b0011};
        vecs[5]  = '{3'b000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0111};
        vecs[6]  = '{3'b001, 4'b1000, 4'd1,    4'b0111, 4'b0000, 4'b0001};
        vecs[7]  = '{3'b100, 4'd3,    4'd1,    4'b0001, 4'b0001, 4'b0000};
        vecs[8]  = '{3'b111, 4'd5,    4'd0,    4'b1010, 4'b1111, 4'b1000};
        vecs[9]  = '{3'b010, 4'b1111, 4'd0,    4'b0000, 4'b0001, 4'b0110};
        vecs[10] = '{3'b101, 4'd0,    4'd0,    4'b0000, 4'b0000, 4'b0100};

        rst = 1'b1;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        #12;
        rst = 1'b0;
        step();

        // Reset / idle state
        check("reset out_valid", out_valid, 1'b0);
        check("reset in_ready",  in_ready,  1'b1);
        check("reset count",     count,     0);
        check("reset out_flags", out_flags, 4'b0000);
        check("reset out_y",     out_y,     4'd0);
        check("reset out_op",    out_op,    3'd0);

        // Flag vector table: push one entry, inspect head, pop it
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].cout, 1'b0);
            step();
            check($sformatf("vec%0d out_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d out_y", i),     out_y,     vecs[i].y);
            check($sformatf("vec%0d out_op", i),    out_op,    vecs[i].op);
            check($sformatf("vec%0d out_flags", i), out_flags, vecs[i].flags);
            drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
            step();
            check($sformatf("vec%0d drained", i), out_valid, 1'b0);
        end

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 9) < 6);
            r    = $urandom_range(0, 1);
            op   = 3'($urandom);
            a    = 4'($urandom);
            b    = 4'($urandom);
            cout = 4'($urandom);
            y    = alu_ref(op, a, b);
            drive(v, op, a, b, y, cout, r);
            exp_push = v && (model_q.size() < DEPTH);
            exp_pop  = r && (model_q.size() > 0);
            step();
            if (exp_pop) void'(model_q.pop_front());
            if (exp_push) begin
                e.op    = op;
                e.y     = y;
                e.flags = ref_flags(op, a, b, y, cout);
                model_q.push_back(e);
            end
            check("rand count",     count,     model_q.size());
            check("rand out_valid", out_valid, model_q.size() > 0);
            check("rand in_ready",  in_ready,  model_q.size() < DEPTH);
            if (model_q.size() > 0) begin
                check("rand out_y",     out_y,     model_q[0].y);
                check("rand out_op",    out_op,    model_q[0].op);
                check("rand out_flags", out_flags, model_q[0].flags);
            end
        end

        // Drain before the hand-written sequences
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step();
        check("drain count", count, 0);

        // Fill to DEPTH, refused push, pop under full, ordered drain
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 3'b100, 4'd0, 4'd0, 4'(i + 1), 4'd0, 1'b0);
            step();
        end
        check("full count",    count,    DEPTH);
        check("full in_ready", in_ready, 1'b0);
        check("full head",     out_y,    4'd1);
        drive(1'b1, 3'b100, 4'd0, 4'd0, 4'd9, 4'd0, 1'b0);
        step();
        check("full no push count", count, DEPTH);
        check("full no push head",  out_y, 4'd1);
        drive(1'b1, 3'b100, 4'd0, 4'd0, 4'd9, 4'd0, 1'b1);
        step();
        check("full pop count",    count,    DEPTH - 1);
        check("full pop in_ready", in_ready, 1'b1);
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int i = 2; i <= DEPTH; i++) begin
            check($sformatf("drain order %0d", i), out_y, 4'(i));
            check($sformatf("drain flags %0d", i), out_flags, 4'b0000);
            step();
        end
        check("wrap empty valid", out_valid, 1'b0);
        check("wrap empty count", count,     0);
        check("wrap stale y",     out_y,     4'd1);
        step();
        check("empty pop ignored count", count, 0);
        check("empty pop ignored y",     out_y, 4'd1);

        // Steady streaming then asynchronous reset mid-stream
        drive(1'b1, 3'b000, 4'd2, 4'd3, 4'd5, 4'd0, 1'b1);
        step();
        check("stream first count", count, 1);
        check("stream first y",     out_y, 4'd5);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 3'b000, 4'd0, 4'(k), 4'(k), 4'd0, 1'b1);
            step();
            check($sformatf("stream count %0d", k), count, 1);
            check($sformatf("stream y %0d", k),     out_y, 4'(k));
        end
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", out_valid, 1'b0);
        check("async rst count",     count,     0);
        check("async rst in_ready",  in_ready,  1'b1);
        check("async rst out_y",     out_y,     4'd0);
        #1;
        rst = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step();
        check("post rst count", count, 0);

`ifdef ALU_STICKY_FLAGS_EN
        // Sticky flags: accumulate over pops, clear wins over same-cycle pop
        check("sticky reset", sticky_flags, 4'b0000);
        drive(1'b1, 3'b100, 4'd0, 4'd0, 4'b1000, 4'd0, 1'b0);
        step();
        drive(1'b1, 3'b000, 4'd1, 4'd1, 4'd2, 4'b0001, 1'b0);
        step();
        check("sticky pre pop", sticky_flags, 4'b0000);
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        step();
        check("sticky after pop1", sticky_flags, 4'b1000);
        step();
        check("sticky after pop2", sticky_flags, 4'b1010);
        drive(1'b1, 3'b110, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step();
        sticky_clr = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        step();
        sticky_clr = 1'b0;
        check("sticky clr wins", sticky_flags, 4'b0000);
        check("sticky clr pop happened", count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_result_stage
